// File: rtl/gray_counter.sv
// gray_counter: registered up/down Gray-code counter with Gray-coded load.
// Counts in binary internally. The Gray output is derived from the next binary
// value and registered on the same edge, so bin and gray are never skewed.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (bin, gray, tc forced to 0)
//   en         advance one step this cycle
//   up         direction when en=1 (1 = increment, 0 = decrement)
//   load       synchronous load; takes priority over en
//   load_gray  Gray-coded value to load
//   bin        registered binary count
//   gray       registered Gray count, always bin ^ (bin >> 1)
//   tc         registered one-cycle terminal-count pulse
module gray_counter #(
   parameter int unsigned WIDTH    = 4,
   parameter bit          SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_gray,
   output logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray,
   output logic             tc
);

   localparam logic [WIDTH-1:0] MAX_VAL  = '1;
   localparam logic [WIDTH-1:0] ZERO_VAL = '0;

   logic [WIDTH-1:0] bin_q,  bin_d;
   logic [WIDTH-1:0] gray_q, gray_d;
   logic             tc_q,   tc_d;
   logic [WIDTH-1:0] load_bin;

   // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      load_bin = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         load_bin[i] = ^(load_gray >> i);
      end
   end

   // Next-state: load > en > hold; tc pulses only on a boundary step.
   always_comb begin
      bin_d = bin_q;
      tc_d  = 1'b0;
      if (load) begin
         bin_d = load_bin;
      end else if (en) begin
         if (up) begin
            if (bin_q == MAX_VAL) begin
               tc_d  = 1'b1;
               bin_d = SATURATE ? bin_q : ZERO_VAL;
            end else begin
               bin_d = bin_q + WIDTH'(1);
            end
         end else begin
            if (bin_q == ZERO_VAL) begin
               tc_d  = 1'b1;
               bin_d = SATURATE ? bin_q : MAX_VAL;
            end else begin
               bin_d = bin_q - WIDTH'(1);
            end
         end
      end
      gray_d = bin_d ^ (bin_d >> 1);
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_q  <= '0;
         gray_q <= '0;
         tc_q   <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         gray_q <= gray_d;
         tc_q   <= tc_d;
      end
   end

   assign bin  = bin_q;
   assign gray = gray_q;
   assign tc   = tc_q;

endmodule
